// File: rtl/f_pc_unit_pkg.sv
// Shared CPU constants for the fetch-stage PC unit: reset/handler addresses,
// the legal text-segment window, exception codes and the redirect FSM encoding.
package f_pc_unit_pkg;

  localparam logic [31:0] PC_RESET    = 32'h0000_3000;
  localparam logic [31:0] EXC_HANDLER = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO     = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI     = 32'h0000_6FFC;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // RUN: fetch follows the normal next-PC path.
  // HOLD: an eret target is parked until the stall releases.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } pc_state_e;

  // A fetch address is legal when word-aligned and inside the text segment.
  function automatic logic addr_is_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr >= TEXT_LO) && (addr <= TEXT_HI);
  endfunction

endpackage

// File: rtl/f_pc_check.sv
// Fetch address legality check: raises AdEL for misaligned or out-of-text
// fetch addresses, purely combinational.
module f_pc_check
  import f_pc_unit_pkg::*;
(
  input  logic [31:0] i_pc,
  output logic [4:0]  o_exc_code
);

  logic w_legal;

  assign w_legal    = addr_is_legal(i_pc);
  assign o_exc_code = w_legal ? EXC_NONE : EXC_ADEL;

endmodule

// File: rtl/f_pc_unit.sv
// Fetch-stage program counter with exception entry, eret redirect and a
// one-entry holding slot for an eret that arrives while fetch is stalled.
module f_pc_unit
  import f_pc_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_newPC,
  input  logic        stall,
  input  logic        Req,
  input  logic        eret,
  input  logic [31:0] EPC,
  input  logic        D_isBranchJump,
  output logic [31:0] F_PC,
  output logic [4:0]  F_ExcCode,
  output logic        F_BD,
  output logic        F_ErPending
);

  pc_state_e   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_epc;

  pc_state_e   w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pend_epc_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_pc       <= PC_RESET;
      r_pend_epc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend_epc <= w_pend_epc_nxt;
    end
  end

  // Priority: Req > eret > HOLD release > stall > normal advance.
  always_comb begin
    // NOTE: defaults first means every path assigns every output, so no
    // latches are inferred and the "hold" case falls out for free.
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_epc_nxt = r_pend_epc;

    if (Req) begin
      w_state_nxt    = ST_RUN;
      w_pc_nxt       = EXC_HANDLER;
      w_pend_epc_nxt = '0;
    end else if (eret) begin
      if (stall) begin
        w_state_nxt    = ST_HOLD;
        w_pend_epc_nxt = EPC;
      end else begin
        w_state_nxt    = ST_RUN;
        w_pc_nxt       = EPC;
        w_pend_epc_nxt = '0;
      end
    end else if (r_state == ST_HOLD) begin
      if (!stall) begin
        w_state_nxt    = ST_RUN;
        w_pc_nxt       = r_pend_epc;
        w_pend_epc_nxt = '0;
      end
    end else if (!stall) begin
      w_pc_nxt = F_newPC;
    end
  end

  f_pc_check u_check (
    .i_pc       (r_pc),
    .o_exc_code (F_ExcCode)
  );

  assign F_PC        = r_pc;
  assign F_ErPending = (r_state == ST_HOLD);
  // The instruction fetched while an eret target is parked is discarded, so
  // it can never be a delay slot.
  assign F_BD        = D_isBranchJump & (r_state != ST_HOLD);

endmodule

// File: tb/tb_f_pc_unit.sv
// Self-checking bench for f_pc_unit: directed scenarios plus a randomized
// run compared against a behavioural model of the fetch PC rules.
module tb_f_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] F_newPC;
  logic        stall;
  logic        Req;
  logic        eret;
  logic [31:0] EPC;
  logic        D_isBranchJump;
  logic [31:0] F_PC;
  logic [4:0]  F_ExcCode;
  logic        F_BD;
  logic        F_ErPending;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [31:0] m_pc   = 32'h0;
  logic        m_hold = 1'b0;
  logic [31:0] m_pend = 32'h0;

  f_pc_unit dut (
    .clk            (clk),
    .reset          (reset),
    .F_newPC        (F_newPC),
    .stall          (stall),
    .Req            (Req),
    .eret           (eret),
    .EPC            (EPC),
    .D_isBranchJump (D_isBranchJump),
    .F_PC           (F_PC),
    .F_ExcCode      (F_ExcCode),
    .F_BD           (F_BD),
    .F_ErPending    (F_ErPending)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] model_exc(input logic [31:0] pc);
    if (pc % 4 != 0)        return 5'd4;
    if (pc < 32'h0000_3000) return 5'd4;
    if (pc > 32'h0000_6FFC) return 5'd4;
    return 5'd0;
  endfunction

  // Apply the current inputs to the model, then advance one clock and
  // settle outputs 1 time unit after the edge.
  task automatic step();
    if (reset) begin
      m_pc = 32'h3000; m_hold = 1'b0; m_pend = 32'h0;
    end else if (Req) begin
      m_pc = 32'h4180; m_hold = 1'b0; m_pend = 32'h0;
    end else if (eret && stall) begin
      m_hold = 1'b1; m_pend = EPC;
    end else if (eret) begin
      m_pc = EPC; m_hold = 1'b0;
    end else if (m_hold && !stall) begin
      m_pc = m_pend; m_hold = 1'b0;
    end else if (!stall) begin
      m_pc = F_newPC;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; Req = 1'b0; eret = 1'b0; stall = 1'b0;
    EPC = 32'h0; D_isBranchJump = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; F_newPC = 32'h1234_5678; D_isBranchJump = 1'b1;
    step();
    n_checks += 4;
    if (F_PC !== 32'h3000) begin n_errors++; $display("FAIL reset_pc: got %h exp %h", F_PC, 32'h3000); end
    if (F_ExcCode !== 5'd0) begin n_errors++; $display("FAIL reset_exc: got %0d exp 0", F_ExcCode); end
    if (F_ErPending !== 1'b0) begin n_errors++; $display("FAIL reset_erp: got %b exp 0", F_ErPending); end
    if (F_BD !== 1'b1) begin n_errors++; $display("FAIL reset_bd: got %b exp 1", F_BD); end
    reset = 1'b0; D_isBranchJump = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      F_newPC = 32'h3000 + 32'(4 * i);
      step();
      n_checks++;
      if (F_PC !== 32'h3000 + 32'(4 * i)) begin
        n_errors++; $display("FAIL seq_pc%0d: got %h exp %h", i, F_PC, 32'h3000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    F_newPC = 32'h3010; step();
    stall = 1'b1; F_newPC = 32'h3400;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (F_PC !== 32'h3010) begin n_errors++; $display("FAIL stall_hold%0d: got %h exp 3010", i, F_PC); end
    end
    stall = 1'b0; step();
    n_checks++;
    if (F_PC !== 32'h3400) begin n_errors++; $display("FAIL stall_release: got %h exp 3400", F_PC); end
  endtask

  task automatic test_eret_hold();
    eret = 1'b1; EPC = 32'h3020; stall = 1'b1; D_isBranchJump = 1'b1; F_newPC = 32'h3500;
    step();
    n_checks += 3;
    if (F_ErPending !== 1'b1) begin n_errors++; $display("FAIL eret_erp_set: got %b exp 1", F_ErPending); end
    if (F_PC !== 32'h3400) begin n_errors++; $display("FAIL eret_pc_held: got %h exp 3400", F_PC); end
    if (F_BD !== 1'b0) begin n_errors++; $display("FAIL eret_bd_forced: got %b exp 0", F_BD); end
    eret = 1'b0; stall = 1'b0;
    step();
    n_checks += 3;
    if (F_PC !== 32'h3020) begin n_errors++; $display("FAIL eret_release_pc: got %h exp 3020", F_PC); end
    if (F_ErPending !== 1'b0) begin n_errors++; $display("FAIL eret_erp_clr: got %b exp 0", F_ErPending); end
    if (F_BD !== 1'b1) begin n_errors++; $display("FAIL eret_bd_run: got %b exp 1", F_BD); end
    D_isBranchJump = 1'b0;
    // A second eret while held replaces the parked target.
    eret = 1'b1; stall = 1'b1; EPC = 32'h3030; step();
    EPC = 32'h3040; step();
    eret = 1'b0; EPC = 32'h0; stall = 1'b0; F_newPC = 32'h3600; step();
    n_checks++;
    if (F_PC !== 32'h3040) begin n_errors++; $display("FAIL eret_overwrite: got %h exp 3040", F_PC); end
    // eret with no stall redirects immediately.
    eret = 1'b1; EPC = 32'h3050; step();
    eret = 1'b0;
    n_checks++;
    if (F_PC !== 32'h3050) begin n_errors++; $display("FAIL eret_direct: got %h exp 3050", F_PC); end
  endtask

  task automatic test_req_in_hold();
    eret = 1'b1; EPC = 32'h3020; stall = 1'b1; step();
    eret = 1'b0; Req = 1'b1; step();
    n_checks += 2;
    if (F_PC !== 32'h4180) begin n_errors++; $display("FAIL req_pc: got %h exp 4180", F_PC); end
    if (F_ErPending !== 1'b0) begin n_errors++; $display("FAIL req_erp: got %b exp 0", F_ErPending); end
    Req = 1'b0; stall = 1'b0; F_newPC = 32'h3700; step();
    n_checks++;
    if (F_PC !== 32'h3700) begin n_errors++; $display("FAIL req_pend_discard: got %h exp 3700", F_PC); end
  endtask

  task automatic test_exc_code();
    logic [31:0] addrs [4] = '{32'h3002, 32'h7000, 32'h2FFC, 32'h6FFC};
    logic [4:0]  codes [4] = '{5'd4, 5'd4, 5'd4, 5'd0};
    for (int i = 0; i < 4; i++) begin
      F_newPC = addrs[i]; step();
      n_checks++;
      if (F_ExcCode !== codes[i]) begin
        n_errors++; $display("FAIL exc_code@%h: got %0d exp %0d", addrs[i], F_ExcCode, codes[i]);
      end
    end
  endtask

  task automatic test_reset_priority();
    eret = 1'b1; EPC = 32'h3080; stall = 1'b1; step();
    reset = 1'b1; Req = 1'b1; step();
    n_checks += 2;
    if (F_PC !== 32'h3000) begin n_errors++; $display("FAIL rstprio_pc: got %h exp 3000", F_PC); end
    if (F_ErPending !== 1'b0) begin n_errors++; $display("FAIL rstprio_erp: got %b exp 0", F_ErPending); end
    idle_inputs(); F_newPC = 32'h3100; step();
    n_checks++;
    if (F_PC !== 32'h3100) begin n_errors++; $display("FAIL rstprio_nopend: got %h exp 3100", F_PC); end
  endtask

  function automatic logic [31:0] rand_addr(input logic [31:0] base);
    case ($urandom_range(3))
      0: return base + 32'd4;
      1: return 32'h3000 + ($urandom_range(32'h3FFF) & 32'hFFFF_FFFC);
      2: return 32'h2FF0 + 32'($urandom_range(32'h4020));
      default: return $urandom();
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(49) == 0);
      Req            = ($urandom_range(15) == 0);
      eret           = ($urandom_range(7) == 0);
      stall          = ($urandom_range(2) == 0);
      D_isBranchJump = 1'($urandom_range(1));
      F_newPC        = rand_addr(m_pc);
      EPC            = rand_addr(m_pc);
      step();
      n_checks += 4;
      if (F_PC !== m_pc) begin n_errors++; $display("FAIL rnd_pc[%0d]: got %h exp %h", i, F_PC, m_pc); end
      if (F_ErPending !== m_hold) begin n_errors++; $display("FAIL rnd_erp[%0d]: got %b exp %b", i, F_ErPending, m_hold); end
      if (F_ExcCode !== model_exc(m_pc)) begin
        n_errors++; $display("FAIL rnd_exc[%0d]: got %0d exp %0d", i, F_ExcCode, model_exc(m_pc));
      end
      if (F_BD !== (D_isBranchJump & ~m_hold)) begin
        n_errors++; $display("FAIL rnd_bd[%0d]: got %b exp %b", i, F_BD, D_isBranchJump & ~m_hold);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    F_newPC = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_eret_hold();
    test_req_in_hold();
    test_exc_code();
    test_reset_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/f_pc_unit.md
F_PC_UNIT -- requirements
Module: f_pc_unit

Interface
REQ-001 SHALL provide: clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL provide: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL provide: F_newPC  in  32  next fetch address from the decode-stage next-PC logic (PC+4, branch, jal or jr target).
REQ-004 SHALL provide: stall  in  1  hazard-unit freeze of the fetch stage.
REQ-005 SHALL provide: Req  in  1  exception/interrupt taken this cycle (from CP0).
REQ-006 SHALL provide: eret  in  1  eret present in decode stage.
REQ-007 SHALL provide: EPC  in  32  return address from CP0, sampled when eret is honoured.
REQ-008 SHALL provide: D_isBranchJump  in  1  decode-stage instruction is a branch or jump.
REQ-009 SHALL provide: F_PC  out  32  current fetch address (registered).
REQ-010 SHALL provide: F_ExcCode  out  5  fetch exception code; 0 = none, 4 = AdEL.
REQ-011 SHALL provide: F_BD  out  1  fetched instruction occupies a delay slot.
REQ-012 SHALL provide: F_ErPending  out  1  an eret redirect is latched, waiting for stall to drop.

Function
REQ-013 SHALL hold a 2-state FSM: RUN (no pending redirect), HOLD (eret latched during stall).
REQ-014 SHALL apply per-cycle priority: reset > Req > eret > HOLD release > stall > normal advance.
REQ-015 SHALL, on Req=1, load F_PC=0x00004180, regardless of stall, eret or state; FSM -> RUN; pending EPC discarded.
REQ-016 SHALL, on eret=1, stall=0, Req=0, load F_PC=EPC; FSM -> RUN.
REQ-017 SHALL, on eret=1, stall=1, Req=0, hold F_PC, latch EPC into pend_epc; FSM -> HOLD.
REQ-018 SHALL, in HOLD with eret=1 again, overwrite pend_epc with the new EPC.
REQ-019 SHALL, in HOLD with stall=0, eret=0, Req=0, load F_PC=pend_epc; FSM -> RUN; F_newPC ignored that cycle.
REQ-020 SHALL, in RUN with stall=1 and no Req/eret, hold F_PC unchanged.
REQ-021 SHALL, in RUN with stall=0 and no Req/eret, load F_PC=F_newPC.
REQ-022 SHALL drive F_ErPending=1 exactly while FSM is HOLD.
REQ-023 SHALL compute F_ExcCode combinationally from F_PC: 4 if F_PC[1:0]!=0, or F_PC<0x00003000, or F_PC>0x00006FFC; else 0.
REQ-024 SHALL compute F_BD combinationally = D_isBranchJump, forced 0 while FSM is HOLD.
REQ-025 SHALL treat all addresses as unsigned 32-bit; no arithmetic is performed in this block, F_newPC is taken verbatim.
REQ-026 SHALL update F_PC with one-cycle latency: an input sampled at edge N is visible on F_PC after edge N.

Reset
REQ-027 SHALL, on reset=1 at a rising edge, set F_PC=0x00003000, FSM=RUN, pend_epc=0, overriding Req, eret and stall.
REQ-028 SHALL, after reset, present F_ExcCode=0, F_ErPending=0, F_BD=D_isBranchJump.
REQ-029 SHALL discard a pending eret when reset is asserted in HOLD.

Structure
REQ-030 SHALL take constants from the shared CPU package: PC_RESET=0x00003000, EXC_HANDLER=0x00004180, TEXT_LO=0x00003000, TEXT_HI=0x00006FFC, EXC_ADEL=5'd4, EXC_NONE=5'd0, and the FSM state encoding.
REQ-031 SHALL instantiate one sub-module, f_pc_check, holding the address-legality comparison that produces F_ExcCode.

Verification
REQ-032 SHALL cover this case: reset, then 3 cycles with F_newPC=F_PC+4, stall=0 -> F_PC 0x3000, 0x3004, 0x3008, 0x300C.
REQ-033 SHALL cover this case: F_PC=0x3010, stall=1 for 2 cycles with F_newPC=0x3400 -> F_PC stays 0x3010; stall=0 -> 0x3400.
REQ-034 SHALL cover this case: eret=1, EPC=0x3020, stall=1 -> F_ErPending=1, F_PC held; stall=0 next cycle -> F_PC=0x3020, F_ErPending=0.
REQ-035 SHALL cover this case: in HOLD with pend_epc=0x3020, Req=1 and stall=1 -> F_PC=0x4180, F_ErPending=0.
REQ-036 SHALL cover this case: F_newPC=0x3002 -> F_ExcCode=4; F_newPC=0x7000 -> 4; F_newPC=0x2FFC -> 4; F_newPC=0x6FFC -> 0.
REQ-037 SHALL cover this case: reset=1 while Req=1 and eret=1 -> F_PC=0x3000, FSM=RUN.
